// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a sync FIFO. A winner keeps the
// grant for up to MaxBurst transfers, or until it drops valid. The grant
// is combinational: a request is granted in the cycle it is raised. The
// payload is muxed straight through; nothing is stored.
module fifo_wr_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int MaxBurst  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          wvalid_o,
  input  logic                          wready_i,
  output logic [DataWidth-1:0]          data_o,
  output logic [$clog2(NumReq)-1:0]     src_id_o,
  output logic [NumReq-1:0]             grant_o
);
  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [CntW:0]    BurstLast = (CntW+1)'(MaxBurst);
  localparam logic [IdW-1:0]   LastId    = IdW'(NumReq - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IdW-1:0]  rr_ptr, owner;
  logic [CntW-1:0] burst_cnt;

  logic            found, active, xfer;
  logic [IdW-1:0]  pick, winner;
  logic [CntW:0]   burst_inc;

  // Index after i, wrapping at NumReq (NumReq need not be a power of 2).
  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] i);
    return (i == LastId) ? '0 : i + 1'b1;
  endfunction

  // Rotating-priority search: first valid requester at or above rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_valid_i[IdW'((int'(rr_ptr) + i) % NumReq)]) begin
        found = 1'b1;
        pick  = IdW'((int'(rr_ptr) + i) % NumReq);
      end
    end
  end

  // While locked the owner alone may drive; dropping valid releases it at once.
  assign winner    = (state == LOCKED) ? owner : pick;
  assign active    = !reset_i && ((state == LOCKED) ? req_valid_i[owner] : found);
  assign xfer      = active && wready_i;
  assign burst_inc = {1'b0, burst_cnt} + 1'b1;

  assign wvalid_o  = active;
  assign src_id_o  = active ? winner : '0;
  assign data_o    = active ? req_data_i[int'(winner)*DataWidth +: DataWidth] : '0;

  for (genvar k = 0; k < NumReq; k++) begin : g_req
    assign grant_o[k]     = active && (winner == IdW'(k));
    assign req_ready_o[k] = grant_o[k] && wready_i;
  end

  // Grant FSM: lock onto a winner, release on burst end or valid drop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            if (xfer && MaxBurst == 1) begin
              rr_ptr <= wrap_inc(pick);
            end else begin
              // Lock on a stall too, so the offered grant cannot move.
              state     <= LOCKED;
              owner     <= pick;
              burst_cnt <= xfer ? CntW'(1) : '0;
            end
          end
        end
        LOCKED: begin
          if (!req_valid_i[owner]) begin
            state  <= IDLE;
            rr_ptr <= wrap_inc(owner);
          end else if (xfer && burst_inc == BurstLast) begin
            state     <= IDLE;
            rr_ptr    <= wrap_inc(owner);
            burst_cnt <= '0;
          end else if (xfer) begin
            burst_cnt <= burst_inc[CntW-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed sequences plus a random run with a
// per-requester data scoreboard and a reference grant model.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        wready;

  logic [3:0]  req_ready, grant, req_ready1, grant1;
  logic        wvalid, wvalid1;
  logic [7:0]  data, data1;
  logic [1:0]  src_id, src_id1;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q [$];
  logic [7:0] item_q [4][$];

  always #5 clk = ~clk;

  fifo_wr_arbiter dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .wvalid_o(wvalid), .wready_i(wready),
    .data_o(data), .src_id_o(src_id), .grant_o(grant)
  );

  fifo_wr_arbiter #(.MaxBurst(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready1), .wvalid_o(wvalid1), .wready_i(wready),
    .data_o(data1), .src_id_o(src_id1), .grant_o(grant1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, queue the expected grant, check all outputs at negedge.
  task automatic apply(input bit sel, input logic [3:0] v, input logic w, input logic [3:0] g);
    logic [3:0] eg;
    logic [1:0] ei;
    req_valid = v;
    wready    = w;
    exp_q.push_back(g);
    @(negedge clk);
    eg = exp_q.pop_front();
    ei = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) ei = 2'(i);
    chk("grant",  sel ? grant1     : grant,     eg);
    chk("src_id", sel ? src_id1    : src_id,    ei);
    chk("wvalid", sel ? wvalid1    : wvalid,    |eg);
    chk("ready",  sel ? req_ready1 : req_ready, eg & {4{w}});
    chk("data",   sel ? data1      : data,      (eg != 0) ? 8'hA0 + {6'd0, ei} : 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_valid = 4'h0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bit         m_lock, mact;
    logic [1:0] m_own, m_ptr, mw, idx;
    int         m_cnt;
    logic [5:0] seq [4];
    logic [3:0] eg;
    logic [7:0] got;

    reset = 1'b1; req_valid = 4'h0; wready = 1'b0;
    req_data = 32'hA3A2A1A0;
    @(posedge clk); #1;

    // Outputs held at zero while reset is high, whatever the inputs.
    apply(0, 4'hF, 1'b1, 4'h0);
    apply(1, 4'hF, 1'b1, 4'h0);
    reset = 1'b0;

    // All requesters valid: bursts of four, rotating 0,1,2,3,0.
    for (int i = 0; i < 17; i++) apply(0, 4'hF, 1'b1, 4'(1 << ((i / 4) % 4)));

    // Stall holds grant on requester 1 through its whole burst.
    do_reset();
    for (int i = 0; i < 3; i++) apply(0, 4'h6, 1'b0, 4'h2);
    for (int i = 0; i < 4; i++) apply(0, 4'h6, 1'b1, 4'h2);
    apply(0, 4'h6, 1'b1, 4'h4);

    // Early release by requester 3; requester 0 wins the following cycle.
    do_reset();
    apply(0, 4'h8, 1'b1, 4'h8);
    apply(0, 4'h8, 1'b1, 4'h8);
    apply(0, 4'h1, 1'b1, 4'h0);
    apply(0, 4'h1, 1'b1, 4'h1);

    // Single-transfer bursts rotate every cycle, skipping requester 2.
    do_reset();
    for (int i = 0; i < 6; i++) apply(1, 4'hB, 1'b1, (i % 3 == 0) ? 4'h1 : (i % 3 == 1) ? 4'h2 : 4'h8);

    // Reset mid-burst aborts, and arbitration restarts at requester 0.
    do_reset();
    apply(0, 4'h4, 1'b1, 4'h4);
    apply(0, 4'h4, 1'b1, 4'h4);
    reset = 1'b1;
    apply(0, 4'hF, 1'b1, 4'h0);
    apply(0, 4'hF, 1'b1, 4'h0);
    reset = 1'b0;
    apply(0, 4'hF, 1'b1, 4'h1);

    // Random traffic against a reference model and per-requester queues.
    do_reset();
    m_lock = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      seq[k] = 6'd0;
      item_q[k].push_back({2'(k), 6'd0});
    end
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) begin
        req_data[k*8 +: 8] = {2'(k), seq[k]};
        req_valid[k] = ($urandom_range(0, 9) < 6);
      end
      wready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      mact = 0; mw = 0;
      if (m_lock) begin
        mw = m_own;
        mact = req_valid[m_own];
      end else begin
        for (int i = 0; i < 4; i++) begin
          idx = m_ptr + 2'(i);
          if (!mact && req_valid[idx]) begin mact = 1; mw = idx; end
        end
      end
      eg = mact ? 4'(1 << mw) : 4'h0;
      chk("rgrant",  grant, eg);
      chk("rready",  req_ready, eg & {4{wready}});
      chk("ronehot", 32'($onehot0(grant)), 32'd1);
      if (mact && wready) begin
        got = item_q[mw].pop_front();
        chk("rdata", data, got);
        seq[mw] = seq[mw] + 6'd1;
        item_q[mw].push_back({mw, seq[mw]});
      end
      if (!m_lock) begin
        if (mact) begin m_lock = 1; m_own = mw; m_cnt = wready ? 1 : 0; end
      end else if (!req_valid[m_own]) begin
        m_lock = 0; m_ptr = m_own + 2'd1;
      end else if (wready && m_cnt + 1 == 4) begin
        m_lock = 0; m_ptr = m_own + 2'd1; m_cnt = 0;
      end else if (wready) begin
        m_cnt++;
      end
      @(posedge clk); #1;
    end
    // Exactly the one not-yet-sent item left per requester: none lost or doubled.
    for (int k = 0; k < 4; k++) chk("pending", 32'(item_q[k].size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
